sram_resp_mem: RTL
==================

Name: sram_resp_mem

Overview:
- Synchronous single-port memory responder for the CPU's SRAM-style interface (en / we / addr / wdata / rdata).
- Serves either the instruction or the data SRAM port in the SoC-lite bench and in the FPGA build.
- Behaviour:
  - byte-lane writes;
  - read data returned after a configurable fixed latency;
  - out-of-range access trapping;
  - access counters for trace and debug.

Parameters:
- ADDR_WIDTH, 14, word-index bits; memory holds 2^ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h1c00_0000, byte base address of the window. Low ADDR_WIDTH+2 bits must be zero.
- LATENCY, 1, read latency in cycles. Legal values 1..4; any other value is an elaboration error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous reset, active low.
- sram_en  in  1  access request this cycle.
- sram_we  in  5  bits [3:0] are byte-lane write enables (bit i covers wdata[8i+7:8i]); bit 4 is reserved and ignored.
- sram_addr  in  32  byte address; bits [1:0] are ignored.
- sram_wdata  in  32  write data.
- sram_rdata  out  32  read data, LATENCY cycles after the request.
- err_flag  out  1  sticky; set on the first out-of-range access.
- err_addr  out  32  sram_addr of the first out-of-range access.
- rd_cnt  out  32  count of read requests.
- wr_cnt  out  32  count of write requests.

Behaviour:
- Request classification:
  - read = sram_en & (sram_we[3:0]==0);
  - write = sram_en & (sram_we[3:0]!=0).
  - Exactly one request per cycle is possible.
- In-range test: sram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]. Index = sram_addr[ADDR_WIDTH+1:2].
- In-range write: at the clock edge, only the enabled byte lanes of mem[index] are updated; other lanes are unchanged.
- Read pipeline: registers stage[0..LATENCY-1]; sram_rdata = stage[LATENCY-1].
  - stage[0] loads on any request: the in-range read loads mem[index]; the in-range write loads the merged new word (write-first); an out-of-range access loads 32'h0.
  - stage[0] holds its value when sram_en=0.
  - stage[k] loads stage[k-1] every cycle, for k >= 1.
- Resulting latency:
  - a request in cycle t is visible on sram_rdata from cycle t+LATENCY;
  - with the port idle, sram_rdata settles on the last returned word;
  - back-to-back reads stream at one word per cycle.
- Read after write: a write to address A in cycle t followed by a read of A in cycle t+1 returns the new data. No hazard window.
- Out-of-range access:
  - any write is suppressed (memory unchanged);
  - rd_cnt/wr_cnt still increment;
  - if err_flag=0: err_flag<=1 and err_addr<=sram_addr;
  - later out-of-range accesses do not change err_addr;
  - err_flag is cleared only by reset.
- Counters: rd_cnt++ on every read, wr_cnt++ on every write; both wrap 32'hffff_ffff -> 0 silently.
- Reset (resetn=0 at an edge):
  - all stages, sram_rdata, err_flag, err_addr, rd_cnt, wr_cnt -> 0;
  - in-flight reads are discarded;
  - requests during reset are ignored (no write, no count);
  - memory contents are not reset.
- First cycle after resetn rises: requests are accepted normally.
- Memory array has no reset; simulation initial contents are X unless preloaded by the bench hierarchically.

Test Plan:
- LATENCY=1; write addr 32'h1c00_0010, we=4'hf, wdata=32'hdead_beef; read the same address next cycle -> sram_rdata=32'hdead_beef one cycle after the read; rd_cnt=1, wr_cnt=1.
- Byte lanes: preload 32'h1122_3344; write we=4'b0101, wdata=32'haabb_ccdd; read -> 32'h11bb_33dd. Repeat with we=5'b10000 -> counted as a read, memory unchanged.
- LATENCY=3; back-to-back reads of words 0,1,2 holding 32'h0,32'h1,32'h2 in cycles t..t+2 -> rdata 0,1,2 in cycles t+3..t+5; rdata stays 32'h2 while idle.
- Out of range: read 32'h0000_0040, then write 32'h2000_0000 -> rdata 0, memory untouched; err_flag=1, err_addr=32'h0000_0040; rd_cnt=1, wr_cnt=1.
- Reset mid-operation: LATENCY=2; read issued, resetn=0 the next cycle -> rdata=0 after reset, counters 0, err_flag 0; memory keeps previously written values.
- Counter wrap: force wr_cnt=32'hffff_ffff, issue one write -> wr_cnt=0, no error flagged.

Source files
------------

// File: rtl/sram_resp_mem.sv
// Single-port SRAM-style responder: byte-lane writes, fixed read latency,
// out-of-range trapping and read/write access counters.
module sram_resp_mem #(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h1c00_0000,
    parameter int          LATENCY    = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [4:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        err_flag,
    output logic [31:0] err_addr,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("sram_resp_mem: LATENCY must be in 1..4");
        end
        if ((BASE_ADDR & ((32'h1 << (ADDR_WIDTH + 2)) - 32'h1)) != 32'h0) begin : g_bad_base
            $error("sram_resp_mem: BASE_ADDR not aligned to the window size");
        end
    endgenerate

    logic [31:0]           mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  in_range;
    logic                  is_rd;
    logic                  is_wr;
    logic [31:0]           merged_word;

    logic [31:0] stage_q [LATENCY];
    logic [31:0] stage_d [LATENCY];
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic        err_flag_q, err_flag_d;
    logic [31:0] err_addr_q, err_addr_d;

    // Reserved we bit and the byte offset carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{sram_we[4], sram_addr[1:0]};

    assign idx      = sram_addr[ADDR_WIDTH+1:2];
    assign in_range = (sram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign is_rd    = sram_en & (sram_we[3:0] == 4'h0);
    assign is_wr    = sram_en & (sram_we[3:0] != 4'h0);

    // Merged word doubles as the write-first read value, so a read never sees a hazard.
    always_comb begin
        merged_word = mem_q[idx];
        for (int i = 0; i < 4; i++) begin
            if (sram_we[i]) begin
                merged_word[8*i +: 8] = sram_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        stage_d    = stage_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;

        if (sram_en) begin
            stage_d[0] = in_range ? merged_word : 32'h0;
            if (!in_range && !err_flag_q) begin
                err_flag_d = 1'b1;
                err_addr_d = sram_addr;
            end
        end
        for (int k = 1; k < LATENCY; k++) begin
            stage_d[k] = stage_q[k-1];
        end
        if (is_rd) rd_cnt_d = rd_cnt_q + 32'h1;
        if (is_wr) wr_cnt_d = wr_cnt_q + 32'h1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < LATENCY; k++) begin
                stage_q[k] <= 32'h0;
            end
            rd_cnt_q   <= 32'h0;
            wr_cnt_q   <= 32'h0;
            err_flag_q <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            stage_q    <= stage_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Storage has no reset; writes are blocked during reset and outside the window.
    always_ff @(posedge clk) begin
        if (resetn && is_wr && in_range) begin
            mem_q[idx] <= merged_word;
        end
    end

    assign sram_rdata = stage_q[LATENCY-1];
    assign err_flag   = err_flag_q;
    assign err_addr   = err_addr_q;
    assign rd_cnt     = rd_cnt_q;
    assign wr_cnt     = wr_cnt_q;

endmodule
